sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single 16-bit SDRAM controller between two requesters: port 0 = mem_shim
//  (MPEG2 frame-store traffic, high priority) and port 1 = bitstream loader / HPS path.
//  Each port sees the controller's native handshake: one-cycle rd/wr strobe when !busy,
//  one-cycle ack on completion. Sits between the requesters and the SDRAM controller.
// PARAMETERS
//  ADDR_W       25    SDRAM byte-address width
//  DATA_W       16    SDRAM data width
//  MAX_WAIT     8     consecutive port-1 losses before port 1 is forced to win (>=1)
//  ACK_TIMEOUT  1023  cycles from strobe to ack before abort; 0 = timeout disabled
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset, asynchronous, active-low
//  pN_addr      in   ADDR_W  port N (N=0,1) byte address, sampled on strobe
//  pN_rd        in   1       port N read strobe (one cycle)
//  pN_wr        in   1       port N write strobe (one cycle)
//  pN_din       in   DATA_W  port N write data, sampled on strobe
//  pN_dout      out  DATA_W  port N read data, valid while pN_ack=1
//  pN_ack       out  1       port N completion pulse
//  pN_busy      out  1       port N may not strobe
//  sdram_addr   out  ADDR_W  to controller
//  sdram_rd     out  1       to controller, one-cycle pulse
//  sdram_wr     out  1       to controller, one-cycle pulse
//  sdram_din    out  DATA_W  to controller
//  sdram_dout   in   DATA_W  from controller, valid with sdram_ack
//  sdram_ack    in   1       from controller, completion pulse
//  sdram_busy   in   1       from controller
//  owner        out  1       port holding the controller (last granted when idle)
//  err_timeout  out  1       sticky: an access was aborted by ACK_TIMEOUT
//  err_overrun  out  1       sticky: a strobe arrived while that port was busy
// BEHAVIOUR
//  Reset: all outputs 0, pending regs empty, state S_IDLE, wait_cnt 0, timer 0.
//  Capture: strobe in cycle T with pending empty -> latch addr/din/op; pN_busy=1 from T+1
//   until the cycle after pN_ack. rd&wr together = write. Strobe while pending set:
//   ignored, err_overrun<=1.
//  pN_busy = pending_N | sdram_busy (the latter so an idle ported requester still sees
//   controller backpressure).
//  FSM S_IDLE: if !sdram_busy and any pending: pick winner, drive sdram_addr/din, pulse
//   sdram_rd or sdram_wr (registered, visible T+2 for a strobe at T), owner<=winner,
//   timer<=0, ->S_WAIT. Else stay.
//  FSM S_WAIT: sdram_ack -> pN_dout<=sdram_dout, pN_ack<=1 (cycle A+1) for owner only,
//   clear owner pending, ->S_IDLE. Timer counts each cycle; at ACK_TIMEOUT (non-zero)
//   without ack: pN_ack<=1, pN_dout<=0, clear pending, err_timeout<=1, ->S_IDLE.
//  Arbitration: port 0 wins unless wait_cnt==MAX_WAIT and port 1 pending. Port 1 pending
//   and loses -> wait_cnt+1 (saturating at MAX_WAIT); port 1 granted -> wait_cnt<=0.
//  sdram_ack in S_IDLE (stray, or post-reset leftover) discarded; no pN_ack.
//  New strobe on a port may occur the cycle pN_busy drops (after pN_ack); next grant in
//   S_IDLE that cycle+1 earliest; back-to-back accesses cost no idle cycle beyond this.
//  sdram_addr/din hold last granted values between accesses.
//  Reset mid-access: everything cleared; requester must reissue.
// STRUCTURE
//  Package sdram_arb_pkg: state enum (S_IDLE,S_WAIT), PORT_MPEG=0/PORT_AUX=1 constants,
//   req_t struct {addr, din, is_wr, valid}.
//  Sub-module sdram_req_latch (one per port): capture, overrun detect, pending clear.
//  Top: FSM, priority/starvation counter, timeout timer, response routing.
// TESTING
//  1 p0 rd 0x000100, controller acks after 5 cycles with 0xBEEF -> sdram_rd at T+2,
//    p0_ack once with p0_dout=0xBEEF, p1_ack stays 0.
//  2 p0,p1 write strobe same cycle -> p0 served first, p1 second; owner 0 then 1.
//  3 p0 strobes continuously, p1 one pending, MAX_WAIT=8 -> p1 granted on 9th grant,
//    wait_cnt back to 0.
//  4 ACK_TIMEOUT=16, controller never acks -> p0_ack at 17 cycles after grant,
//    p0_dout=0, err_timeout=1, next request served normally.
//  5 p1 strobes again while pending -> ignored, err_overrun=1, single sdram_wr issued.
//  6 Assert rst_n low during S_WAIT, then ack arrives after release -> no pN_ack,
//    all outputs 0, state S_IDLE.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: FSM states, port ids, request record.
package sdram_arb_pkg;

    localparam int ARB_ADDR_W = 25;
    localparam int ARB_DATA_W = 16;

    localparam logic PORT_MPEG = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] din;
        logic                  is_wr;
        logic                  valid;
    } req_t;

endpackage

// File: rtl/sdram_req_latch.sv
// Per-port request holder: captures a strobe, flags strobes that land while a
// request is still pending, and drops the request when the arbiter retires it.
module sdram_req_latch
    import sdram_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ARB_ADDR_W-1:0] addr,
    input  logic [ARB_DATA_W-1:0] din,
    input  logic                  rd,
    input  logic                  wr,
    input  logic                  clr,
    output req_t                  req,
    output logic                  overrun
);

    // Combinational so the sticky error in the top lands the cycle after the bad strobe.
    assign overrun = req.valid & (rd | wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req <= '0;
        end else if (req.valid) begin
            if (clr)
                req.valid <= 1'b0;
        end else if (rd | wr) begin
            req.addr  <= addr;
            req.din   <= din;
            req.is_wr <= wr;
            req.valid <= 1'b1;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester front end for the SDRAM controller: fixed priority to the MPEG
// port with a starvation escape for the aux port, plus an ack watchdog.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int MAX_WAIT    = 8,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_rd,
    input  logic              p0_wr,
    input  logic [DATA_W-1:0] p0_din,
    output logic [DATA_W-1:0] p0_dout,
    output logic              p0_ack,
    output logic              p0_busy,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_rd,
    input  logic              p1_wr,
    input  logic [DATA_W-1:0] p1_din,
    output logic [DATA_W-1:0] p1_dout,
    output logic              p1_ack,
    output logic              p1_busy,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rd,
    output logic              sdram_wr,
    output logic [DATA_W-1:0] sdram_din,
    input  logic [DATA_W-1:0] sdram_dout,
    input  logic              sdram_ack,
    input  logic              sdram_busy,
    output logic              owner,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int TMR_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    req_t              req0, req1, win;
    logic              ovr0, ovr1, clr0, clr1;
    logic              pick1, tmo, done;
    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TMR_W-1:0]  timer;

    sdram_req_latch u_lat0 (
        .clk(clk), .rst_n(rst_n), .addr(p0_addr), .din(p0_din), .rd(p0_rd), .wr(p0_wr),
        .clr(clr0), .req(req0), .overrun(ovr0)
    );

    sdram_req_latch u_lat1 (
        .clk(clk), .rst_n(rst_n), .addr(p1_addr), .din(p1_din), .rd(p1_rd), .wr(p1_wr),
        .clr(clr1), .req(req1), .overrun(ovr1)
    );

    // Controller backpressure is folded in so an idle requester still honours it.
    assign p0_busy = req0.valid | sdram_busy;
    assign p1_busy = req1.valid | sdram_busy;

    assign pick1 = req1.valid && (!req0.valid || wait_cnt == WAIT_W'(MAX_WAIT));
    assign win   = pick1 ? req1 : req0;
    assign tmo   = (ACK_TIMEOUT != 0) && (timer == TMR_W'(ACK_TIMEOUT));
    assign done  = (state == S_WAIT) && (sdram_ack || tmo);
    assign clr0  = done && (owner == PORT_MPEG);
    assign clr1  = done && (owner == PORT_AUX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            timer       <= '0;
            owner       <= PORT_MPEG;
            sdram_addr  <= '0;
            sdram_din   <= '0;
            sdram_rd    <= 1'b0;
            sdram_wr    <= 1'b0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_dout     <= '0;
            p1_dout     <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            sdram_rd <= 1'b0;
            sdram_wr <= 1'b0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            if (ovr0 | ovr1)
                err_overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    // Acks seen here are strays (late or from before reset) and are dropped.
                    if (!sdram_busy && (req0.valid || req1.valid)) begin
                        owner      <= pick1;
                        sdram_addr <= win.addr;
                        sdram_din  <= win.din;
                        sdram_wr   <= win.is_wr;
                        sdram_rd   <= !win.is_wr;
                        timer      <= '0;
                        state      <= S_WAIT;
                        if (pick1)
                            wait_cnt <= '0;
                        else if (req1.valid && wait_cnt != WAIT_W'(MAX_WAIT))
                            wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        if (owner == PORT_AUX) begin
                            p1_ack  <= 1'b1;
                            p1_dout <= sdram_ack ? sdram_dout : '0;
                        end else begin
                            p0_ack  <= 1'b1;
                            p0_dout <= sdram_ack ? sdram_dout : '0;
                        end
                        if (!sdram_ack)
                            err_timeout <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus queues expected controller
// commands and port responses; a monitor compares them as the DUT produces them.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] p0_addr, p1_addr, sdram_addr;
    logic        p0_rd, p0_wr, p1_rd, p1_wr;
    logic [15:0] p0_din, p1_din, p0_dout, p1_dout, sdram_din, sdram_dout;
    logic        p0_ack, p0_busy, p1_ack, p1_busy;
    logic        sdram_rd, sdram_wr, sdram_ack, sdram_busy;
    logic        owner, err_timeout, err_overrun;

    typedef struct packed {
        logic        wr;
        logic        port;
        logic [24:0] addr;
        logic [15:0] din;
    } cmd_t;

    typedef struct packed {
        logic        port;
        logic [15:0] dout;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   ack_dly = 5;
    bit   no_ack  = 1'b0;
    bit   gap_en  = 1'b0;

    sdram_port_arbiter #(.ADDR_W(25), .DATA_W(16), .MAX_WAIT(8), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(p0_addr), .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_din(p0_din),
        .p0_dout(p0_dout), .p0_ack(p0_ack), .p0_busy(p0_busy),
        .p1_addr(p1_addr), .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_din(p1_din),
        .p1_dout(p1_dout), .p1_ack(p1_ack), .p1_busy(p1_busy),
        .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
        .sdram_din(sdram_din), .sdram_dout(sdram_dout), .sdram_ack(sdram_ack),
        .sdram_busy(sdram_busy), .owner(owner),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rdata(input logic [24:0] a);
        rdata = (a == 25'h100) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction

    task automatic push(input logic wr, input logic port, input logic [24:0] a,
                        input logic [15:0] d, input logic has_rsp, input logic [15:0] rd_exp);
        cmd_q.push_back('{wr: wr, port: port, addr: a, din: d});
        if (has_rsp)
            rsp_q.push_back('{port: port, dout: rd_exp});
    endtask

    // Called on a negedge; holds the strobes for one cycle and returns on the next negedge.
    task automatic strb(input logic r0, input logic w0, input logic [24:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [24:0] a1, input logic [15:0] d1);
        p0_rd = r0; p0_wr = w0; p0_addr = a0; p0_din = d0;
        p1_rd = r1; p1_wr = w1; p1_addr = a1; p1_din = d1;
        @(negedge clk);
        p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
    endtask

    task automatic drain(input string name, input int lim);
        int n = 0;
        while ((cmd_q.size() != 0 || rsp_q.size() != 0 || dut.state != S_IDLE) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n >= lim), 64'd0);
    endtask

    task automatic outs_zero(input string name);
        chk({name, "_data"}, {16'd0, p0_dout, p1_dout, sdram_din}, 64'd0);
        chk({name, "_ctrl"}, {30'd0, p0_ack, p0_busy, p1_ack, p1_busy, sdram_addr, sdram_rd,
                              sdram_wr, owner, err_timeout, err_overrun}, 64'd0);
    endtask

    // SDRAM controller model: acks ack_dly cycles after a command, optional busy gap after ack.
    initial begin
        int          cnt = 0;
        bit          gap_pend = 1'b0;
        logic [24:0] caddr = '0;
        sdram_ack = 1'b0; sdram_busy = 1'b0; sdram_dout = '0;
        forever begin
            @(negedge clk);
            sdram_ack  = 1'b0;
            sdram_busy = gap_pend;
            gap_pend   = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    sdram_ack  = 1'b1;
                    sdram_dout = rdata(caddr);
                    gap_pend   = gap_en;
                end
            end
            if (sdram_rd || sdram_wr) begin
                caddr = sdram_addr;
                cnt   = no_ack ? 0 : ack_dly;
            end
        end
    end

    // Monitor: pops and compares every controller command and every port ack.
    initial begin
        cmd_t ec;
        rsp_t er;
        forever begin
            @(negedge clk);
            if (sdram_rd || sdram_wr) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", {21'd0, sdram_wr, owner, sdram_addr, sdram_din}, 64'd0);
                end else begin
                    ec = cmd_q.pop_front();
                    chk("cmd", {21'd0, sdram_wr, owner, sdram_addr, sdram_din}, {21'd0, ec});
                    chk("cmd_rd_xor_wr", 64'(sdram_rd ^ sdram_wr), 64'd1);
                end
            end
            if (p0_ack || p1_ack) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {46'd0, p1_ack, p0_ack, p1_ack ? p1_dout : p0_dout}, 64'd0);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_ack_port", {62'd0, p1_ack, p0_ack}, er.port ? 64'd2 : 64'd1);
                    chk("rsp_dout", 64'(er.port ? p1_dout : p0_dout), 64'(er.dout));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        p0_rd = 1'b0; p0_wr = 1'b0; p0_addr = '0; p0_din = '0;
        p1_rd = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_din = '0;
        repeat (3) @(negedge clk);
        outs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single p0 read, controller acks 5 cycles later with BEEF
        ack_dly = 5;
        push(1'b0, 1'b0, 25'h100, 16'h0000, 1'b1, 16'hBEEF);
        strb(1'b1, 1'b0, 25'h100, 16'h0000, 1'b0, 1'b0, 25'h0, 16'h0);
        chk("t1_rd_T1", 64'(sdram_rd), 64'd0);
        chk("t1_busy_T1", 64'(p0_busy), 64'd1);
        @(negedge clk);
        chk("t1_rd_T2", 64'(sdram_rd), 64'd1);
        drain("t1", 40);
        chk("t1_busy_after", 64'(p0_busy), 64'd0);

        // 2: simultaneous writes, p0 first then p1
        push(1'b1, 1'b0, 25'h200, 16'h1111, 1'b1, 16'h585A);
        push(1'b1, 1'b1, 25'h300, 16'h2222, 1'b1, 16'h595A);
        strb(1'b0, 1'b1, 25'h200, 16'h1111, 1'b0, 1'b1, 25'h300, 16'h2222);
        drain("t2", 60);
        chk("t2_owner", 64'(owner), 64'd1);

        // 3: saturated p0 vs one pending p1; busy gap after each ack lets p0 re-queue
        gap_en = 1'b1; ack_dly = 2;
        for (int i = 0; i < 8; i++)
            push(1'b0, 1'b0, 25'h1000 + 25'(i), 16'h0, 1'b1, 16'h4A5A ^ 16'(i));
        push(1'b1, 1'b1, 25'h700, 16'h7777, 1'b1, 16'h5D5A);
        push(1'b0, 1'b0, 25'h1008, 16'h0, 1'b1, 16'h4A52);
        strb(1'b1, 1'b0, 25'h1000, 16'h0, 1'b0, 1'b1, 25'h700, 16'h7777);
        for (int i = 1; i <= 8; i++) begin
            n = 0;
            while (!p0_ack && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("t3_p0_ack_wait", 64'(n >= 60), 64'd0);
            strb(1'b1, 1'b0, 25'h1000 + 25'(i), 16'h0, 1'b0, 1'b0, 25'h700, 16'h7777);
        end
        drain("t3", 200);
        chk("t3_wait_cnt", 64'(dut.wait_cnt), 64'd0);
        gap_en = 1'b0;
        repeat (2) @(negedge clk);

        // 4: controller never acks -> abort 17 cycles after the command
        chk("t4_err_timeout_pre", 64'(err_timeout), 64'd0);
        no_ack = 1'b1;
        push(1'b0, 1'b0, 25'h400, 16'h0, 1'b1, 16'h0000);
        strb(1'b1, 1'b0, 25'h400, 16'h0, 1'b0, 1'b0, 25'h0, 16'h0);
        @(negedge clk);
        chk("t4_rd_T2", 64'(sdram_rd), 64'd1);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (p0_ack) break;
        end
        chk("t4_latency", 64'(n), 64'd17);
        @(negedge clk);
        chk("t4_err_timeout", 64'(err_timeout), 64'd1);
        no_ack = 1'b0; ack_dly = 3;
        push(1'b0, 1'b0, 25'h500, 16'h0, 1'b1, 16'h5F5A);
        strb(1'b1, 1'b0, 25'h500, 16'h0, 1'b0, 1'b0, 25'h0, 16'h0);
        drain("t4", 40);

        // 5: p1 re-strobes while pending -> ignored, one write only
        chk("t5_err_overrun_pre", 64'(err_overrun), 64'd0);
        ack_dly = 6;
        push(1'b1, 1'b1, 25'h600, 16'h3333, 1'b1, 16'h5C5A);
        strb(1'b0, 1'b0, 25'h0, 16'h0, 1'b0, 1'b1, 25'h600, 16'h3333);
        chk("t5_p1_busy", 64'(p1_busy), 64'd1);
        strb(1'b0, 1'b0, 25'h0, 16'h0, 1'b0, 1'b1, 25'h610, 16'h4444);
        chk("t5_err_overrun", 64'(err_overrun), 64'd1);
        drain("t5", 40);

        // 6: reset during S_WAIT; the late ack must not reach either port
        ack_dly = 10;
        push(1'b0, 1'b0, 25'h700, 16'h0, 1'b0, 16'h0);
        strb(1'b1, 1'b0, 25'h700, 16'h0, 1'b0, 1'b0, 25'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk("t6_in_wait", 64'(dut.state == S_WAIT), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        outs_zero("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        outs_zero("t6_post");
        chk("t6_state", 64'(dut.state == S_IDLE), 64'd1);

        chk("queues_empty", 64'(cmd_q.size() + rsp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
